// File: rtl/clk_div_switch_ctrl.sv
// clk_div_switch_ctrl: sequences run-time changes of the 2-bit clock-divider ratio without glitches
// Ports:
//   clk           clock, also the divider source clock
//   rstn          asynchronous active-low reset
//   req_valid     ratio-change request valid
//   req_coe       requested ratio code (00=/1, 01=/2, 10=/3, 11=/4)
//   req_ready     request is taken on req_valid & req_ready (IDLE only)
//   div_clk_in    divided clock fed back from the divider output
//   err_clr       clears err_timeout
//   div_coe_out   ratio code driven to the divider
//   div_rstn_out  active-low reset driven to the divider
//   gate_en       1 = divided clock may propagate downstream
//   busy          1 = switch sequence in progress
//   err_timeout   sticky: a switch was forced after TIMEOUT cycles in WAIT_LOW
module clk_div_switch_ctrl #(
    parameter logic [1:0] RESET_COE  = 2'b00,
    parameter int         SETTLE_CYC = 4,
    parameter int         TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_valid,
    input  logic [1:0] req_coe,
    output logic       req_ready,
    input  logic       div_clk_in,
    input  logic       err_clr,
    output logic [1:0] div_coe_out,
    output logic       div_rstn_out,
    output logic       gate_en,
    output logic       busy,
    output logic       err_timeout
);
    localparam int CMAX = (TIMEOUT > SETTLE_CYC) ? TIMEOUT : SETTLE_CYC;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] R_LAST = CW'(1);

    typedef enum logic [2:0] {IDLE, WAIT_LOW, GATE, RST_DIV, SETTLE} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    pend, pend_d, coe_d;
    logic          s1, s2, fall, safe, err_set;

    // A falling edge of the divided clock marks the start of its low phase; /1 has no
    // divided phase to wait for, so it is always safe.
    assign fall = s2 & ~s1;
    assign safe = fall | (div_coe_out == 2'b00);

    // Outputs are decoded straight from the state flop so they carry no input paths.
    assign req_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign gate_en      = (state == IDLE) || (state == WAIT_LOW);
    assign div_rstn_out = (state != RST_DIV);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= RST_DIV;
            cnt         <= '0;
            pend        <= RESET_COE;
            div_coe_out <= RESET_COE;
            err_timeout <= 1'b0;
            s1          <= 1'b0;
            s2          <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            pend        <= pend_d;
            div_coe_out <= coe_d;
            err_timeout <= err_set | (err_timeout & ~err_clr);
            s1          <= div_clk_in;
            s2          <= s1;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pend_d  = pend;
        err_set = 1'b0;
        // New ratio lands on the divider together with its reset assertion.
        coe_d   = (state == GATE) ? pend : div_coe_out;
        case (state)
            IDLE: begin
                if (req_valid && req_coe != div_coe_out) begin
                    pend_d  = req_coe;
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (safe || cnt == T_LAST) begin
                    state_d = GATE;
                    cnt_d   = '0;
                    err_set = ~safe;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            GATE: begin
                state_d = RST_DIV;
                cnt_d   = '0;
            end
            RST_DIV: begin
                state_d = (cnt == R_LAST) ? SETTLE : RST_DIV;
                cnt_d   = (cnt == R_LAST) ? '0 : cnt + CW'(1);
            end
            SETTLE: begin
                state_d = (cnt == S_LAST) ? IDLE : SETTLE;
                cnt_d   = (cnt == S_LAST) ? '0 : cnt + CW'(1);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_clk_div_switch_ctrl.sv
// tb_clk_div_switch_ctrl: scenario tasks plus a scoreboard of gated windows for clk_div_switch_ctrl
module tb_clk_div_switch_ctrl;
    logic       clk = 1'b0, rstn = 1'b1, req_valid = 1'b0, div_clk_in = 1'b1, err_clr = 1'b0;
    logic [1:0] req_coe = 2'b00;
    logic       req_ready, div_rstn_out, gate_en, busy, err_timeout;
    logic [1:0] div_coe_out;

    // One record per gated window: its length in cycles, the ratio and error flag when the gate reopens.
    typedef struct packed {logic [7:0] len; logic [1:0] coe; logic err;} rec_t;
    rec_t exp_q[$];
    int   total = 0, passes = 0, low_len = 0;

    always #5 clk = ~clk;

    clk_div_switch_ctrl dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_coe(req_coe), .req_ready(req_ready),
        .div_clk_in(div_clk_in), .err_clr(err_clr), .div_coe_out(div_coe_out),
        .div_rstn_out(div_rstn_out), .gate_en(gate_en), .busy(busy), .err_timeout(err_timeout)
    );

    always @(negedge clk) begin : monitor
        rec_t e, o;
        if (!rstn) low_len = 0;
        else if (!gate_en) low_len++;
        else if (low_len != 0) begin
            o = rec_t'({8'(low_len), div_coe_out, err_timeout});
            total++;
            if (exp_q.size() == 0)
                $display("FAIL sb_unexpected got len=%0d coe=%b err=%b with no window expected", o.len, o.coe, o.err);
            else begin
                e = exp_q.pop_front();
                if (o !== e)
                    $display("FAIL sb_window got len=%0d coe=%b err=%b exp len=%0d coe=%b err=%b",
                             o.len, o.coe, o.err, e.len, e.coe, e.err);
                else passes++;
            end
            low_len = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, %0d/%0d so far", passes, total);
        $fatal(1);
    end

    task automatic send(input logic [1:0] c);
        req_valid = 1'b1;
        req_coe   = c;
        for (int i = 0; i < 60 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 60 && !req_ready; i++) @(negedge clk);
        total++;
        if (!req_ready) $display("FAIL %s_idle_timeout got req_ready=%b exp 1", nm, req_ready);
        else passes++;
    endtask

    task automatic test_reset;
        int n = 0;
        logic coe_bad = 1'b0;
        logic [2:0] rp = 3'b000;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({gate_en, req_ready, busy, div_rstn_out, div_coe_out, err_timeout} !== 7'b0010000)
            $display("FAIL reset_state got %b exp 0010000",
                     {gate_en, req_ready, busy, div_rstn_out, div_coe_out, err_timeout});
        else passes++;
        exp_q.push_back(rec_t'({8'd6, 2'b00, 1'b0}));
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (div_coe_out !== 2'b00) coe_bad = 1'b1;
            if (i < 3) rp[i] = div_rstn_out;
            if (req_ready) break;
            n++;
        end
        total++;
        if (n != 6) $display("FAIL reset_ready_delay got %0d exp 6", n);
        else passes++;
        total++;
        if (rp !== 3'b100) $display("FAIL reset_div_rstn got %b exp 100", rp);
        else passes++;
        total++;
        if (coe_bad || gate_en !== 1'b1) $display("FAIL reset_coe_gate got coe_bad=%b gate_en=%b exp 0 1", coe_bad, gate_en);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_div1_to_div4;
        exp_q.push_back(rec_t'({8'd7, 2'b11, 1'b0}));
        send(2'b11);
        @(negedge clk);
        total++;
        if ({busy, gate_en, req_ready} !== 3'b110) $display("FAIL d4_wait got %b exp 110", {busy, gate_en, req_ready});
        else passes++;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({gate_en, div_coe_out} !== 3'b000) $display("FAIL d4_gate got %b exp 000", {gate_en, div_coe_out});
        else passes++;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({div_coe_out, div_rstn_out} !== 3'b110) $display("FAIL d4_rst got %b exp 110", {div_coe_out, div_rstn_out});
        else passes++;
        wait_idle("d4");
        total++;
        if ({div_coe_out, err_timeout} !== 3'b110) $display("FAIL d4_final got %b exp 110", {div_coe_out, err_timeout});
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_fall_switch;
        logic early = 1'b0;
        exp_q.push_back(rec_t'({8'd7, 2'b10, 1'b0}));
        send(2'b10);
        for (int i = 0; i < 5; i++) begin
            div_clk_in = (i >= 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (i < 4 && !gate_en) early = 1'b1;
            if (i == 4) begin
                total++;
                if (gate_en !== 1'b0) $display("FAIL fall_gate got gate_en=%b exp 0", gate_en);
                else passes++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (early) $display("FAIL fall_early got early_drop=1 exp 0");
        else passes++;
        wait_idle("fall");
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        logic early;
        div_clk_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(rec_t'({8'd7, 2'b01, 1'b0}));
        send(2'b01);
        div_clk_in = 1'b0;
        wait_idle("to_prep");
        @(posedge clk); #1;
        div_clk_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            early = 1'b0;
            exp_q.push_back(rec_t'({8'd7, (pass == 0) ? 2'b10 : 2'b01, 1'b1}));
            send((pass == 0) ? 2'b10 : 2'b01);
            for (int i = 0; i < 17; i++) begin
                err_clr = (pass == 1 && i == 15);
                @(negedge clk);
                if (i < 16 && !gate_en) early = 1'b1;
                if (i == 15) begin
                    total++;
                    if (err_timeout !== 1'b0) $display("FAIL to_pre_err%0d got %b exp 0", pass, err_timeout);
                    else passes++;
                end
                if (i == 16) begin
                    total++;
                    if ({gate_en, err_timeout} !== 2'b01) $display("FAIL to_gate_err%0d got %b exp 01", pass, {gate_en, err_timeout});
                    else passes++;
                end
                @(posedge clk); #1;
            end
            err_clr = 1'b0;
            total++;
            if (early) $display("FAIL to_early%0d got early_drop=1 exp 0", pass);
            else passes++;
            wait_idle("to");
            @(posedge clk); #1;
            err_clr = 1'b1;
            @(posedge clk); #1;
            err_clr = 1'b0;
            @(negedge clk);
            total++;
            if (err_timeout !== 1'b0) $display("FAIL to_clr%0d got %b exp 0", pass, err_timeout);
            else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_same_ratio;
        logic bad = 1'b0, coe_bad = 1'b0;
        req_valid = 1'b1;
        req_coe   = 2'b01;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy || !req_ready || !gate_en || !div_rstn_out) bad = 1'b1;
            if (div_coe_out !== 2'b01) coe_bad = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        total++;
        if (bad) $display("FAIL same_ctrl got disturbance=1 exp 0");
        else passes++;
        total++;
        if (coe_bad) $display("FAIL same_coe got changed=1 exp 0");
        else passes++;
    endtask

    task automatic test_reset_in_settle;
        logic seen = 1'b0, found = 1'b0;
        int n = 0;
        send(2'b11);
        div_clk_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!div_rstn_out) seen = 1'b1;
            if (seen && div_rstn_out && busy) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found || div_coe_out !== 2'b11) $display("FAIL settle_reach got found=%b coe=%b exp 1 11", found, div_coe_out);
        else passes++;
        @(posedge clk); #1;
        rstn      = 1'b0;
        req_valid = 1'b1;
        req_coe   = 2'b10;
        #1;
        total++;
        if ({div_rstn_out, gate_en, div_coe_out, busy, req_ready} !== 6'b000010)
            $display("FAIL settle_abort got %b exp 000010", {div_rstn_out, gate_en, div_coe_out, busy, req_ready});
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(rec_t'({8'd6, 2'b00, 1'b0}));
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
        end
        total++;
        if (n != 6) $display("FAIL held_req_delay got %0d exp 6", n);
        else passes++;
        exp_q.push_back(rec_t'({8'd7, 2'b10, 1'b0}));
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, req_ready} !== 2'b10) $display("FAIL held_req_accept got %b exp 10", {busy, req_ready});
        else passes++;
        wait_idle("held");
        total++;
        if (div_coe_out !== 2'b10) $display("FAIL held_req_coe got %b exp 10", div_coe_out);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_drain;
        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) $display("FAIL sb_drain got %0d pending exp 0", exp_q.size());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_div1_to_div4();
        test_fall_switch();
        test_timeout();
        test_same_ratio();
        test_reset_in_settle();
        test_drain();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
